// File: rtl/condition_pkg.sv
// condition_pkg -- shared constants for the condition block.
//   code_t    : 2-bit select / decode value type
//   DecSel0..3: decode table (sel=0 -> 3, sel=1 -> 2, sel=2 -> 1, sel=3 -> 0)
//   HoldCode  : select code for which the hold registers keep their value
package condition_pkg;

  typedef logic [1:0] code_t;

  localparam code_t DecSel0  = 2'd3;
  localparam code_t DecSel1  = 2'd2;
  localparam code_t DecSel2  = 2'd1;
  localparam code_t DecSel3  = 2'd0;

  localparam code_t HoldCode = 2'd3;

endpackage

// File: rtl/condition_if.sv
// condition_if -- select input and decoded outputs of the condition block.
//   sel            : select code 0..3 (driven by master)
//   normal_if      : combinational decode, if/else form
//   normal_case    : combinational decode, case form
//   normal_ternary : combinational decode, conditional-operator form
//   latch_if       : registered partial decode, if-chain form
//   latch_case     : registered partial decode, case form
interface condition_if;
  import condition_pkg::*;

  code_t sel;
  code_t normal_if;
  code_t normal_case;
  code_t normal_ternary;
  code_t latch_if;
  code_t latch_case;

  modport master (
    output sel,
    input  normal_if,
    input  normal_case,
    input  normal_ternary,
    input  latch_if,
    input  latch_case
  );

  modport slave (
    input  sel,
    output normal_if,
    output normal_case,
    output normal_ternary,
    output latch_if,
    output latch_case
  );

endinterface

// File: rtl/condition_hold_reg.sv
// condition_hold_reg -- 2-bit flop with load enable and async active-low clear.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low clear
//   load_i : load d_i on the next rising edge, otherwise hold
//   d_i    : value to load
//   q_o    : registered value
module condition_hold_reg
  import condition_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  code_t d_i,
  output code_t q_o
);

  code_t q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/condition.sv
// condition -- decodes a 2-bit select three equivalent combinational ways and
// twice as a partial decode into hold registers.
//   clk   : rising-edge clock for the hold registers
//   rst_n : asynchronous active-low reset (hold registers only)
//   bus   : condition_if slave (sel in; normal_* and latch_* out)
module condition
  import condition_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  condition_if.slave bus
);

  code_t sel;
  code_t dec_if;
  code_t dec_case;
  code_t dec_ternary;
  logic  if_load;
  code_t if_d;
  logic  case_load;
  code_t case_d;
  code_t hold_if;
  code_t hold_case;

  assign sel = bus.sel;

  // Fully specified decodes.
  always_comb begin
    if (sel == 2'd0) begin
      dec_if = DecSel0;
    end else if (sel == 2'd1) begin
      dec_if = DecSel1;
    end else if (sel == 2'd2) begin
      dec_if = DecSel2;
    end else begin
      dec_if = DecSel3;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    dec_case = DecSel0;
      2'd1:    dec_case = DecSel1;
      2'd2:    dec_case = DecSel2;
      default: dec_case = DecSel3;
    endcase
  end

  assign dec_ternary = (sel == 2'd0) ? DecSel0 :
                       (sel == 2'd1) ? DecSel1 :
                       (sel == 2'd2) ? DecSel2 : DecSel3;

  // Partial decodes: an uncovered code (HoldCode, or X/Z in 4-state sim)
  // leaves the load enable low so the flop holds; no latch is formed.
  always_comb begin
    if_load = 1'b0;
    if_d    = '0;
    if (sel == 2'd0) begin
      if_load = 1'b1;
      if_d    = DecSel0;
    end else if (sel == 2'd1) begin
      if_load = 1'b1;
      if_d    = DecSel1;
    end else if (sel == 2'd2) begin
      if_load = 1'b1;
      if_d    = DecSel2;
    end
  end

  always_comb begin
    case_load = 1'b0;
    case_d    = '0;
    case (sel)
      2'd0: begin
        case_load = 1'b1;
        case_d    = DecSel0;
      end
      2'd1: begin
        case_load = 1'b1;
        case_d    = DecSel1;
      end
      2'd2: begin
        case_load = 1'b1;
        case_d    = DecSel2;
      end
      default: case_load = 1'b0;  // HoldCode: keep value
    endcase
  end

  condition_hold_reg u_hold_if (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (if_load),
    .d_i    (if_d),
    .q_o    (hold_if)
  );

  condition_hold_reg u_hold_case (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (case_load),
    .d_i    (case_d),
    .q_o    (hold_case)
  );

  assign bus.normal_if      = dec_if;
  assign bus.normal_case    = dec_case;
  assign bus.normal_ternary = dec_ternary;
  assign bus.latch_if       = hold_if;
  assign bus.latch_case     = hold_case;

endmodule

// File: tb/tb_condition.sv
// tb_condition -- directed stimulus against a behavioural model of condition.
module tb_condition;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  logic [1:0] exp_hold;

  condition_if bus ();

  condition dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Model: decode value is 3 - sel; hold registers capture it at a rising
  // edge unless sel is 3, and clear whenever reset is low.
  initial exp_hold = 2'd0;
  always @(negedge rst_n) exp_hold = 2'd0;
  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.sel != 2'd3) exp_hold = 2'd3 - bus.sel;
  end

  // Continuous compare on every falling edge, away from input changes.
  always @(negedge clk) begin
    logic [1:0] exp_norm;
    exp_norm = 2'd3 - bus.sel;
    check("cmp_normal_if", bus.normal_if, exp_norm);
    check("cmp_normal_case", bus.normal_case, exp_norm);
    check("cmp_normal_ternary", bus.normal_ternary, exp_norm);
    check("cmp_latch_if", bus.latch_if, exp_hold);
    check("cmp_latch_case", bus.latch_case, exp_hold);
  end

  task automatic check_latch(input string name, input logic [1:0] exp);
    check({name, "_latch_if"}, bus.latch_if, exp);
    check({name, "_latch_case"}, bus.latch_case, exp);
  endtask

  // Apply sel just after a rising edge, then sample 1 after the next edge.
  task automatic step(input logic [1:0] s);
    bus.sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] dec_tab [4];
    logic [1:0] seq_sel [8];
    logic [1:0] seq_exp [8];
    checks = 0;
    passed = 0;
    dec_tab = '{2'd3, 2'd2, 2'd1, 2'd0};
    seq_sel = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    seq_exp = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd3};

    rst_n   = 1'b0;
    bus.sel = 2'd0;

    // Step sel 0..3 during reset: normals decode immediately, holds read 0.
    for (int i = 0; i < 4; i++) begin
      bus.sel = i[1:0];
      #1;
      check("step_normal_if", bus.normal_if, dec_tab[i]);
      check("step_normal_case", bus.normal_case, dec_tab[i]);
      check("step_normal_ternary", bus.normal_ternary, dec_tab[i]);
      check_latch("in_reset", 2'd0);
    end

    // Release reset with sel=3 held: holds stay 0.
    bus.sel = 2'd3;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_latch("hold_from_reset", 2'd0);
    end

    // Load 1 then hold across three sel=3 edges.
    step(2'd2);
    check_latch("load_two", 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(2'd3);
      check_latch("hold_one", 2'd1);
    end

    // Mixed sequence, one edge each.
    for (int i = 0; i < 8; i++) begin
      step(seq_sel[i]);
      check_latch("seq", seq_exp[i]);
    end

    // Async reset mid-cycle while holding 2.
    step(2'd1);
    check_latch("pre_reset", 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_latch("async_clear", 2'd0);
    @(posedge clk);
    #1;
    check_latch("reset_held", 2'd0);
    #1;
    rst_n = 1'b1;

    // Toggle sel 0 -> 1 between edges: only the edge value is captured.
    bus.sel = 2'd0;
    #4;
    bus.sel = 2'd1;
    @(posedge clk);
    #1;
    check_latch("edge_sample", 2'd2);

    step(2'd3);
    check_latch("final_hold", 2'd2);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
